// File: rtl/alu_op_sequencer.sv
// Sequences A, B and opcode loads from a shared bus into a combinational ALU, then registers the result.
// Optional illegal-opcode checking is enabled by defining ALU_OP_SEQUENCER_OPCHK_EN.
module alu_op_sequencer #(
  parameter int NB_DATA  = 6,
  parameter int NB_OP    = 6,
  parameter int NB_STATE = 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NB_DATA-1:0]  i_data,
  input  logic                i_load,
  input  logic                i_clear,
  input  logic [NB_DATA-1:0]  i_alu_res,
  output logic [NB_DATA-1:0]  o_alu_a,
  output logic [NB_DATA-1:0]  o_alu_b,
  output logic [NB_OP-1:0]    o_alu_op,
  output logic [NB_DATA-1:0]  o_res,
  output logic                o_valid,
  output logic [NB_STATE-1:0] o_state,
  output logic                o_err
);

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_OP   = 2'b10,
    S_EXEC = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic               load_d;
  logic               load_ev;
  logic [NB_DATA-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic               valid_q, valid_d;

`ifdef ALU_OP_SEQUENCER_OPCHK_EN
  logic err_q, err_d;

  function automatic logic legal_op(input logic [NB_OP-1:0] op);
    case (op)
      NB_OP'(6'b100000), NB_OP'(6'b100010), NB_OP'(6'b100100), NB_OP'(6'b100101),
      NB_OP'(6'b100110), NB_OP'(6'b000011), NB_OP'(6'b000010), NB_OP'(6'b100111):
        legal_op = 1'b1;
      default: legal_op = 1'b0;
    endcase
  endfunction
`endif

  // A held button must produce a single event, so act only on the rising edge of the level.
  assign load_ev = i_load & ~load_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_A;
      load_d  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
`ifdef ALU_OP_SEQUENCER_OPCHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      load_d  <= i_load;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      valid_q <= valid_d;
`ifdef ALU_OP_SEQUENCER_OPCHK_EN
      err_q   <= err_d;
`endif
    end
  end

  // Clear outranks any load; the EXEC cycle always completes and ignores load events.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    valid_d = valid_q;
`ifdef ALU_OP_SEQUENCER_OPCHK_EN
    err_d   = err_q;
`endif
    if (i_clear) begin
      state_d = S_A;
      a_d     = '0;
      b_d     = '0;
      op_d    = '0;
      res_d   = '0;
      valid_d = 1'b0;
`ifdef ALU_OP_SEQUENCER_OPCHK_EN
      err_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        S_A: if (load_ev) begin
          a_d     = i_data;
          valid_d = 1'b0;
          state_d = S_B;
        end
        S_B: if (load_ev) begin
          b_d     = i_data;
          state_d = S_OP;
        end
        S_OP: if (load_ev) begin
          op_d = i_data[NB_OP-1:0];
`ifdef ALU_OP_SEQUENCER_OPCHK_EN
          if (legal_op(i_data[NB_OP-1:0])) begin
            err_d   = 1'b0;
            state_d = S_EXEC;
          end else begin
            err_d   = 1'b1;
          end
`else
          state_d = S_EXEC;
`endif
        end
        S_EXEC: begin
          res_d   = i_alu_res;
          valid_d = 1'b1;
          state_d = S_A;
        end
        default: state_d = S_A;
      endcase
    end
  end

  assign o_alu_a  = a_q;
  assign o_alu_b  = b_q;
  assign o_alu_op = op_q;
  assign o_res    = res_q;
  assign o_valid  = valid_q;
  assign o_state  = NB_STATE'(state_q);
`ifdef ALU_OP_SEQUENCER_OPCHK_EN
  assign o_err    = err_q;
`else
  assign o_err    = 1'b0;
`endif

endmodule
